ks_1_pipe: RTL
==============

Name: ks_1_pipe

Overview:
- Operand-intake and pre-processing stage of the 16-bit Kogge-Stone adder.
- Accepts operands A/B, carry-in and an add/subtract select over a valid/ready handshake.
- Computes bitwise propagate/generate and the effective carry-in, and registers them.
- Presents i_c0/i_pk/i_gk directly to the level-2 prefix stage. A 2-entry skid buffer breaks the ready path, so the adder can be pipelined and back-pressured.

Parameters:
- WIDTH, 16, operand width. Must be 16 when driving the level-2 prefix stage; other values are legal for standalone use.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_valid  in  1  upstream has an operand pair
- o_ready  out  1  stage can accept an operand pair this cycle
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- i_c0  in  1  carry-in (add) / borrow-in (subtract)
- i_sub  in  1  1 = compute A - B - borrow, 0 = A + B + carry
- o_valid  out  1  output holds a valid p/g set
- i_ready  in  1  downstream accepts this cycle
- o_c0  out  1  effective carry-in to the prefix tree
- o_pk  out  WIDTH  propagate bits
- o_gk  out  WIDTH  generate bits

Behaviour:
- Pre-processing (combinational on the input side, before storage):
  - b_eff = i_sub ? ~i_b : i_b
  - pk = i_a ^ b_eff
  - gk = i_a & b_eff
  - c0_eff = i_c0 ^ i_sub
  - Stored word = {c0_eff, pk, gk}, 2*WIDTH+1 bits.
- Handshake:
  - in_fire = i_valid & o_ready
  - out_fire = o_valid & i_ready
  - Upstream must hold i_a/i_b/i_c0/i_sub stable while i_valid=1 and o_ready=0. Downstream sees stable outputs while o_valid=1 and i_ready=0.
- Storage: output register OUT (drives o_*) and skid register SKID.
- State encoding: EMPTY / ONE / TWO.
  - o_valid = (state != EMPTY)
  - o_ready = (state != TWO); registered state only, no combinational path from i_ready.
- Transitions:
  - EMPTY: in_fire -> load OUT, go to ONE.
  - ONE:
    - in_fire & out_fire -> load OUT with the new word, stay in ONE.
    - in_fire & !out_fire -> load SKID, go to TWO.
    - !in_fire & out_fire -> go to EMPTY.
    - Otherwise hold.
  - TWO (o_ready=0): out_fire -> OUT <= SKID, go to ONE. Otherwise hold.
- Latency: 1 cycle from in_fire to o_valid when empty. Throughput is one per cycle with i_ready held high.
- Order is strictly FIFO; no word is dropped or duplicated.
- Reset (asynchronous, i_rst high):
  - state = EMPTY, o_valid = 0, o_ready = 1.
  - o_pk = 0, o_gk = 0, o_c0 = 0; SKID cleared.
  - Reset mid-operation discards both entries immediately.
  - Inputs are ignored while i_rst is high. First acceptance is possible on the first edge after deassertion.
- Data registers update only on the load conditions above. Outputs hold value when stalled.

Decomposition:
- Shared package holds:
  - KS_WIDTH = 16
  - state localparams ST_EMPTY/ST_ONE/ST_TWO
  - packed word layout (C0 bit index, PK and GK field offsets), so later pipelined prefix stages reuse the same format.
- One sub-module is natural: ks_pg_gen, purely combinational, producing b_eff/pk/gk/c0_eff. The top holds only the skid FSM and registers.

Test Plan:
- Reset, then i_valid=1, i_a=0x1234, i_b=0x0F0F, i_c0=0, i_sub=0 with i_ready=1 -> next cycle o_valid=1, o_pk=0x1D3B, o_gk=0x0204, o_c0=0.
- Subtract: i_a=0x0005, i_b=0x0003, i_sub=1, i_c0=0 -> o_pk=0xFFF9, o_gk=0x0004, o_c0=1. With i_c0=1 -> o_c0=0.
- Back-pressure: i_ready=0, send words W1,W2 on consecutive cycles -> after W2, state TWO and o_ready=0. W3 held at input is not accepted. Raise i_ready -> W1, W2, W3 emerge in order on consecutive cycles, none lost.
- Streaming: i_valid=i_ready=1 for 100 random pairs -> one output per cycle after 1-cycle latency. o_ready stays 1. Each output matches the reference p/g/c0 model.
- Async reset in state TWO (assert i_rst mid-cycle) -> o_valid drops to 0 and o_ready goes to 1 without a clock edge. Outputs are 0. No stale word appears after deassertion.
- Edge operands: i_a=0xFFFF, i_b=0x0001, add, c0=1 -> o_pk=0xFFFE, o_gk=0x0001, o_c0=1. i_a=i_b=0x0000 with i_sub=1 -> o_pk=0xFFFF, o_gk=0x0000, o_c0=1.

Source files
------------

// File: rtl/ks_1_pipe_pkg.sv
// ks_1_pipe_pkg: shared width, skid-buffer states and packed p/g word layout
// for the Kogge-Stone adder pipeline.
//   KS_WIDTH  operand width expected by the level-2 prefix stage
//   state_t   EMPTY / ONE / TWO occupancy of the intake skid buffer
//   word layout {c0, pk[W-1:0], gk[W-1:0]}: gk at bit 0, pk above it, c0 on top
package ks_1_pipe_pkg;
    localparam int KS_WIDTH = 16;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
    localparam int GK_LSB = 0;
    function automatic int pk_lsb(input int w);
        return w;
    endfunction
    function automatic int c0_bit(input int w);
        return 2 * w;
    endfunction
    function automatic int word_w(input int w);
        return 2 * w + 1;
    endfunction
endpackage

// File: rtl/ks_1_pipe_pg_gen.sv
// ks_pg_gen: combinational propagate/generate and effective carry-in.
//   i_a, i_b  operands
//   i_c0      carry-in (add) / borrow-in (subtract)
//   i_sub     1 = A - B - borrow, 0 = A + B + carry
//   o_pk      propagate bits  a ^ b_eff
//   o_gk      generate bits   a & b_eff
//   o_c0      effective carry-in c0 ^ sub
module ks_pg_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_pk,
    output logic [WIDTH-1:0] o_gk,
    output logic             o_c0
);
    logic [WIDTH-1:0] b_eff;
    // Subtraction is A + ~B + 1, so the borrow-in inverts into a carry-in.
    assign b_eff = i_sub ? ~i_b : i_b;
    assign o_pk  = i_a ^ b_eff;
    assign o_gk  = i_a & b_eff;
    assign o_c0  = i_c0 ^ i_sub;
endmodule

// File: rtl/ks_1_pipe.sv
// ks_1_pipe: operand intake stage of the Kogge-Stone adder with a 2-entry skid buffer.
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready   upstream handshake for i_a, i_b, i_c0, i_sub
//   o_valid / i_ready   downstream handshake for o_c0, o_pk, o_gk
//   o_ready depends on registered state only, so i_ready never reaches it.
module ks_1_pipe
    import ks_1_pipe_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_c0,
    output logic [WIDTH-1:0] o_pk,
    output logic [WIDTH-1:0] o_gk
);
    localparam int WW  = word_w(WIDTH);
    localparam int PKL = pk_lsb(WIDTH);
    localparam int C0B = c0_bit(WIDTH);

    logic [WIDTH-1:0] pk, gk;
    logic             c0;
    logic [WW-1:0]    in_word, out_q, out_d, skid_q, skid_d;
    state_t           state_q, state_d;
    logic             in_fire, out_fire;

    ks_pg_gen #(.WIDTH(WIDTH)) u_pg (
        .i_a  (i_a),
        .i_b  (i_b),
        .i_c0 (i_c0),
        .i_sub(i_sub),
        .o_pk (pk),
        .o_gk (gk),
        .o_c0 (c0)
    );

    assign in_word  = {c0, pk, gk};
    assign o_valid  = state_q != ST_EMPTY;
    assign o_ready  = state_q != ST_TWO;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign o_c0     = out_q[C0B];
    assign o_pk     = out_q[PKL +: WIDTH];
    assign o_gk     = out_q[GK_LSB +: WIDTH];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                out_d   = in_fire ? in_word : out_q;
                state_d = in_fire ? ST_ONE : ST_EMPTY;
            end
            ST_ONE: begin
                // A new word replaces OUT only when OUT leaves this cycle;
                // otherwise it parks in SKID behind OUT.
                out_d   = (in_fire & out_fire) ? in_word : out_q;
                skid_d  = (in_fire & ~out_fire) ? in_word : skid_q;
                state_d = (in_fire & ~out_fire) ? ST_TWO :
                          (~in_fire & out_fire) ? ST_EMPTY : ST_ONE;
            end
            ST_TWO: begin
                out_d   = out_fire ? skid_q : out_q;
                state_d = out_fire ? ST_ONE : ST_TWO;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end
endmodule
